axil_bcast_wr_ctrl: RTL and testbench

Write-broadcast sequencer for a one-slave-to-M_COUNT-master AXI4-lite fan-out. It accepts a single AXI-lite write on the slave port and issues it to every master lane enabled in m_en. It then collects all B responses and returns one merged B response upstream. Only one write is outstanding at a time. The read path is out of scope.

---
 rtl/axil_bcast_wr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_axil_bcast_wr_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_bcast_wr_ctrl.sv
// AXI4-lite write broadcaster: one slave write is replayed to every enabled master
// lane, and the lane B responses are merged into a single upstream B response.
module axil_bcast_wr_ctrl #(
    parameter int M_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [M_COUNT-1:0]            m_en,

    input  logic [ADDR_WIDTH-1:0]         s_axil_awaddr,
    input  logic [2:0]                    s_axil_awprot,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [DATA_WIDTH-1:0]         s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]         s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,

    output logic [M_COUNT*ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [M_COUNT*3-1:0]          m_axil_awprot,
    output logic [M_COUNT-1:0]            m_axil_awvalid,
    input  logic [M_COUNT-1:0]            m_axil_awready,
    output logic [M_COUNT*DATA_WIDTH-1:0] m_axil_wdata,
    output logic [M_COUNT*STRB_WIDTH-1:0] m_axil_wstrb,
    output logic [M_COUNT-1:0]            m_axil_wvalid,
    input  logic [M_COUNT-1:0]            m_axil_wready,
    input  logic [M_COUNT*2-1:0]          m_axil_bresp,
    input  logic [M_COUNT-1:0]            m_axil_bvalid,
    output logic [M_COUNT-1:0]            m_axil_bready,

    output logic                          busy,
    output logic [M_COUNT-1:0]            last_err_mask
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [2:0]              prot_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [STRB_WIDTH-1:0]   strb_reg;
    logic [M_COUNT-1:0]      aw_pend_reg, w_pend_reg, b_pend_reg;
    logic [1:0]              resp_acc_reg;
    logic [M_COUNT-1:0]      err_acc_reg;
    logic                    bvalid_reg;
    logic [1:0]              bresp_reg;
    logic [M_COUNT-1:0]      last_err_reg;

    logic                    accept;
    logic [M_COUNT-1:0]      b_hs;
    logic [M_COUNT-1:0]      aw_pend_next, w_pend_next, b_pend_next;
    logic [1:0]              resp_acc_next;
    logic [M_COUNT-1:0]      err_acc_next;

    // AW and W are only ever taken together so every lane sees a complete write.
    assign accept         = (state_reg == IDLE) && s_axil_awvalid && s_axil_wvalid;
    assign s_axil_awready = accept;
    assign s_axil_wready  = accept;
    assign s_axil_bvalid  = bvalid_reg;
    assign s_axil_bresp   = bresp_reg;
    assign busy           = (state_reg != IDLE);
    assign last_err_mask  = last_err_reg;

    // Pend masks are nonzero only in ISSUE, so they double as the lane valids.
    assign m_axil_awvalid = aw_pend_reg;
    assign m_axil_wvalid  = w_pend_reg;
    assign m_axil_bready  = b_pend_reg & ~aw_pend_reg & ~w_pend_reg;
    assign b_hs           = m_axil_bvalid & m_axil_bready;

    generate
        for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_lane
            assign m_axil_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = addr_reg;
            assign m_axil_awprot[gi*3 +: 3]                   = prot_reg;
            assign m_axil_wdata[gi*DATA_WIDTH +: DATA_WIDTH]  = data_reg;
            assign m_axil_wstrb[gi*STRB_WIDTH +: STRB_WIDTH]  = strb_reg;
        end
    endgenerate

    always_comb begin
        aw_pend_next  = aw_pend_reg & ~(aw_pend_reg & m_axil_awready);
        w_pend_next   = w_pend_reg & ~(w_pend_reg & m_axil_wready);
        b_pend_next   = b_pend_reg & ~b_hs;
        resp_acc_next = resp_acc_reg;
        err_acc_next  = err_acc_reg;
        for (int i = 0; i < M_COUNT; i++) begin
            if (b_hs[i]) begin
                if (m_axil_bresp[i*2 +: 2] > resp_acc_next)
                    resp_acc_next = m_axil_bresp[i*2 +: 2];
                err_acc_next[i] = |m_axil_bresp[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            prot_reg     <= '0;
            data_reg     <= '0;
            strb_reg     <= '0;
            aw_pend_reg  <= '0;
            w_pend_reg   <= '0;
            b_pend_reg   <= '0;
            resp_acc_reg <= '0;
            err_acc_reg  <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= '0;
            last_err_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg     <= s_axil_awaddr;
                        prot_reg     <= s_axil_awprot;
                        data_reg     <= s_axil_wdata;
                        strb_reg     <= s_axil_wstrb;
                        aw_pend_reg  <= m_en;
                        w_pend_reg   <= m_en;
                        b_pend_reg   <= m_en;
                        resp_acc_reg <= '0;
                        err_acc_reg  <= '0;
                        if (m_en == '0) begin
                            // Nobody to write to: answer immediately with DECERR.
                            state_reg    <= RESP;
                            bvalid_reg   <= 1'b1;
                            bresp_reg    <= 2'b11;
                            last_err_reg <= '0;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    aw_pend_reg  <= aw_pend_next;
                    w_pend_reg   <= w_pend_next;
                    b_pend_reg   <= b_pend_next;
                    resp_acc_reg <= resp_acc_next;
                    err_acc_reg  <= err_acc_next;
                    if ((aw_pend_next | w_pend_next | b_pend_next) == '0) begin
                        state_reg    <= RESP;
                        bvalid_reg   <= 1'b1;
                        bresp_reg    <= resp_acc_next;
                        last_err_reg <= err_acc_next;
                    end
                end
                RESP: begin
                    if (s_axil_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_bcast_wr_ctrl.sv
// Directed bench for axil_bcast_wr_ctrl with M_COUNT=4 and a scripted master
// model per lane (programmable AW ready delay and B response).
module tb_axil_bcast_wr_ctrl;

    localparam int M = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [M-1:0]  m_en = '0;
    logic [31:0]   s_awaddr = '0;
    logic [2:0]    s_awprot = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [31:0]   s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b0;
    logic [M*32-1:0] m_awaddr;
    logic [M*3-1:0]  m_awprot;
    logic [M-1:0]    m_awvalid, m_awready;
    logic [M*32-1:0] m_wdata;
    logic [M*4-1:0]  m_wstrb;
    logic [M-1:0]    m_wvalid, m_wready;
    logic [M*2-1:0]  m_bresp;
    logic [M-1:0]    m_bvalid, m_bready;
    logic            busy;
    logic [M-1:0]    last_err_mask;

    int errors = 0;
    int checks = 0;

    // master model configuration and state
    int         aw_dly   [M];
    logic [1:0] resp_cfg [M];
    int         aw_wait  [M];
    logic [M-1:0] aw_got, w_got;

    always #5 clk = ~clk;

    axil_bcast_wr_ctrl #(.M_COUNT(M), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .m_en(m_en),
        .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid),
        .s_axil_awready(s_awready), .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb),
        .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready), .s_axil_bresp(s_bresp),
        .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
        .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
        .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
        .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .busy(busy), .last_err_mask(last_err_mask)
    );

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_mst
            assign m_awready[gi]       = (aw_wait[gi] >= aw_dly[gi]);
            assign m_wready[gi]        = 1'b1;
            assign m_bvalid[gi]        = aw_got[gi] & w_got[gi];
            assign m_bresp[gi*2 +: 2]  = resp_cfg[gi];

            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    aw_wait[gi] <= 0;
                    aw_got[gi]  <= 1'b0;
                    w_got[gi]   <= 1'b0;
                end else begin
                    if (m_awvalid[gi] && m_awready[gi]) begin
                        aw_got[gi]  <= 1'b1;
                        aw_wait[gi] <= 0;
                    end else if (m_awvalid[gi]) begin
                        aw_wait[gi] <= aw_wait[gi] + 1;
                    end
                    if (m_wvalid[gi] && m_wready[gi])
                        w_got[gi] <= 1'b1;
                    if (m_bvalid[gi] && m_bready[gi]) begin
                        aw_got[gi] <= 1'b0;
                        w_got[gi]  <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one write and returns one cycle after the accept edge (T+1).
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [M-1:0] en);
        int n;
        s_awaddr = a; s_awprot = 3'b010; s_wdata = d; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; m_en = en;
        #1;
        n = 0;
        while (!s_awready && n < 20) begin
            step();
            n++;
        end
        check("accept", s_awready, 1'b1);
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0; m_en = ~en;
    endtask

    task automatic wait_bvalid(output int n);
        n = 0;
        while (!s_bvalid && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic finish_b();
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;
        check("b_done_bvalid", s_bvalid, 1'b0);
        check("b_done_busy", busy, 1'b0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < M; i++) begin
            aw_dly[i] = 0;
            resp_cfg[i] = 2'b00;
        end
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_awvalid", m_awvalid, 4'h0);
        check("rst_bvalid", s_bvalid, 1'b0);
        check("rst_err", last_err_mask, 4'h0);
        step();
        rst = 1'b0;
        step();

        // Basic broadcast, minimum latency
        send(32'h1000, 32'hDEADBEEF, 4'hF);
        check("t1_awvalid", m_awvalid, 4'hF);
        check("t1_wvalid", m_wvalid, 4'hF);
        check("t1_awaddr", m_awaddr, {4{32'h0000_1000}});
        check("t1_wdata", m_wdata, {4{32'hDEADBEEF}});
        check("t1_wstrb", m_wstrb, 16'hFFFF);
        check("t1_busy", busy, 1'b1);
        wait_bvalid(n);
        check("t1_latency", n, 2);
        check("t1_bresp", s_bresp, 2'b00);
        check("t1_err", last_err_mask, 4'h0);
        finish_b();

        // Lane 2 AW ready delayed 5 cycles
        aw_dly[2] = 5;
        send(32'h2000, 32'h1234_5678, 4'hF);
        step();
        check("t2_awvalid_T2", m_awvalid, 4'b0100);
        check("t2_wvalid_T2", m_wvalid, 4'b0000);
        check("t2_bready_T2", m_bready, 4'b1011);
        step();
        check("t2_awvalid_T3", m_awvalid, 4'b0100);
        check("t2_bready_T3", m_bready, 4'b0000);
        check("t2_addr2", m_awaddr[2*32 +: 32], 32'h2000);
        wait_bvalid(n);
        check("t2_latency", n, 5);
        check("t2_bresp", s_bresp, 2'b00);
        check("t2_awvalid_end", m_awvalid, 4'b0000);
        finish_b();
        aw_dly[2] = 0;

        // Error responses on lanes 1 and 3 in the same cycle
        resp_cfg[1] = 2'b10; resp_cfg[3] = 2'b11;
        send(32'h3000, 32'hCAFE_F00D, 4'hF);
        wait_bvalid(n);
        check("t3_latency", n, 2);
        check("t3_bresp", s_bresp, 2'b11);
        check("t3_err", last_err_mask, 4'b1010);
        finish_b();
        resp_cfg[1] = 2'b00; resp_cfg[3] = 2'b00;

        // No lanes enabled
        send(32'h4000, 32'h0, 4'h0);
        check("t4_bvalid", s_bvalid, 1'b1);
        check("t4_bresp", s_bresp, 2'b11);
        check("t4_busy", busy, 1'b1);
        check("t4_awvalid", m_awvalid, 4'h0);
        check("t4_wvalid", m_wvalid, 4'h0);
        check("t4_err", last_err_mask, 4'h0);
        finish_b();

        // Upstream back-pressure on B with the next write already waiting
        resp_cfg[0] = 2'b01;
        send(32'h5000, 32'h5555_AAAA, 4'b0011);
        wait_bvalid(n);
        resp_cfg[0] = 2'b00;
        s_awaddr = 32'h6000; s_wdata = 32'h6666_6666; m_en = 4'b0011;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t5_hold_bvalid", s_bvalid, 1'b1);
            check("t5_hold_bresp", s_bresp, 2'b01);
            check("t5_hold_awready", s_awready, 1'b0);
            step();
        end
        s_bready = 1'b1;
        #1;
        check("t5_hs_awready", s_awready, 1'b0);
        step();
        s_bready = 1'b0;
        check("t5_bvalid_gone", s_bvalid, 1'b0);
        check("t5_next_awready", s_awready, 1'b1);
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("t5_next_awaddr", m_awaddr[32 +: 32], 32'h6000);
        wait_bvalid(n);
        check("t5_next_bresp", s_bresp, 2'b00);
        finish_b();

        // Asynchronous reset in the middle of ISSUE
        aw_dly[0] = 10; aw_dly[1] = 10;
        send(32'h7000, 32'h7777_7777, 4'hF);
        step();
        check("t6_pending", m_awvalid, 4'b0011);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_awvalid", m_awvalid, 4'h0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_bvalid", s_bvalid, 1'b0);
        aw_dly[0] = 0; aw_dly[1] = 0;
        step();
        rst = 1'b0;
        step();
        send(32'h8000, 32'h8888_8888, 4'hF);
        check("t6_after_addr", m_awaddr, {4{32'h0000_8000}});
        wait_bvalid(n);
        check("t6_after_latency", n, 2);
        check("t6_after_bresp", s_bresp, 2'b00);
        finish_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
